// File: rtl/psr_stage.sv
// psr_stage -- parametrised two-entry pipeline stage register.
//
// Holds up to two payloads between two processor pipeline stages. The LEFT
// entry (_p0) captures from upstream, and the RIGHT entry (_p1) drives out_data.
// While a payload sits in LEFT, any set of its FIELD_W-wide fields can be
// overwritten in place. The overwrite is applied on the same edge that moves
// the entry to RIGHT, or it is kept in LEFT while the entry waits.
//
// Configuration macro: PSR_STALL_CNT_EN
//   defined   -> stall_cnt counts edges with out_valid=1 & out_ready=0 and
//                saturates at 16'hFFFF. Only clr clears it.
//   undefined -> stall_cnt is tied to 16'h0000 and has no counter flops.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   clr        in   1      synchronous reset, active-high, overrides all inputs
//   in_data    in   WIDTH  upstream payload
//   in_valid   in   1      upstream has payload
//   in_ready   out  1      stage accepts payload this cycle
//   out_data   out  WIDTH  RIGHT entry payload
//   out_valid  out  1      RIGHT entry holds payload
//   out_ready  in   1      downstream consumes RIGHT this cycle
//   fld_we     in   NF     per-field overwrite enable for the LEFT entry
//   fld_data   in   WIDTH  overwrite data, bit-aligned with the payload
//   flush      in   1      discard both entries
//   stall_cnt  out  16     stall cycle counter
module psr_stage #(
  parameter int WIDTH   = 33,
  parameter int FIELD_W = 8
) (
  input  logic                                 clk,
  input  logic                                 clr,
  input  logic [WIDTH-1:0]                     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [WIDTH-1:0]                     out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic [(WIDTH+FIELD_W-1)/FIELD_W-1:0] fld_we,
  input  logic [WIDTH-1:0]                     fld_data,
  input  logic                                 flush,
  output logic [15:0]                          stall_cnt
);

  localparam int NF = (WIDTH + FIELD_W - 1) / FIELD_W;

  if (WIDTH < 1 || FIELD_W < 1 || FIELD_W > WIDTH) begin : g_bad_cfg
    $error("psr_stage: WIDTH must be >= 1 and FIELD_W must lie in 1..WIDTH");
  end

  function automatic logic [WIDTH-1:0] fld_merge(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] upd,
                                                 input logic [WIDTH-1:0] mask);
    return (cur & ~mask) | (upd & mask);
  endfunction

  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  logic [WIDTH-1:0] fld_mask;
  logic [WIDTH-1:0] mrg_p0;
  logic             adv;
  logic             take;

  // Expand the per-field enables to a per-bit mask. The last field may be
  // partial, and its mask bits stop at WIDTH-1.
  for (genvar j = 0; j < WIDTH; j++) begin : g_mask
    assign fld_mask[j] = fld_we[j / FIELD_W];
  end

  // fld_we has no visible effect while LEFT is empty, because mrg_p0 is only
  // consumed when vld_p0 is set.
  assign mrg_p0   = fld_merge(data_p0, fld_data, fld_mask);
  assign adv      = vld_p0 & (~vld_p1 | out_ready);
  assign in_ready = ~clr & ~flush & (~vld_p0 | adv);
  assign take     = in_valid & in_ready;

  // Stage boundary: upstream -> LEFT (p0) -> RIGHT (p1)
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (adv) begin
        data_p1 <= mrg_p0;
        vld_p1  <= 1'b1;
      end else if (out_ready && vld_p1) begin
        vld_p1  <= 1'b0;
      end

      // A newly taken payload never sees fld_data. Only a payload that is
      // waiting in LEFT keeps the overwrite.
      if (take) begin
        data_p0 <= in_data;
        vld_p0  <= 1'b1;
      end else if (adv) begin
        vld_p0  <= 1'b0;
      end else if (vld_p0) begin
        data_p0 <= mrg_p0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

`ifdef PSR_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_p1;

  // Flush holds the count. Only clr clears it.
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_p1 <= 16'h0000;
    end else if (!flush && vld_p1 && !out_ready) begin
      stall_cnt_p1 <= sat_inc16(stall_cnt_p1);
    end
  end

  assign stall_cnt = stall_cnt_p1;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_psr_stage.sv
// Testbench for psr_stage (WIDTH=33, FIELD_W=8, NF=5).
// The reference model keeps the stage contents as an ordered queue of
// payloads plus a flag that marks whether the queue head is presented on the
// output.
module tb_psr_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic [32:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fld_we;
  logic [32:0] fld_data;
  logic        flush;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [32:0] mq[$];
  bit          m_head = 1'b0;
  logic [32:0] m_last = '0;
  logic [15:0] m_cnt  = '0;

  psr_stage #(.WIDTH(33), .FIELD_W(8)) dut (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fld_we(fld_we), .fld_data(fld_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_merge(input logic [32:0] cur,
                                            input logic [32:0] fd,
                                            input logic [4:0] we);
    logic [32:0] v;
    logic [4:0]  w;
    v = cur;
    for (int b = 0; b < 33; b++) begin
      w = we >> (b / 8);
      if (w[0]) v[b] = fd[b];
    end
    return v;
  endfunction

  // Drive one cycle's inputs, compare the pre-edge outputs with the model,
  // then advance the model to the state after the coming edge.
  task automatic drive(input logic iv, input logic [32:0] id, input logic ordy,
                       input logic [4:0] we, input logic [32:0] fd,
                       input logic fl, input logic cl);
    bit          left_occ;
    bit          adv;
    logic        e_rdy;
    logic [32:0] e_od;
    logic [15:0] e_cnt;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy;
    fld_we = we; fld_data = fd; flush = fl; clr = cl;
    #1;
    left_occ = (mq.size() == 2) || (mq.size() == 1 && !m_head);
    adv      = left_occ && (!m_head || ordy);
    e_rdy    = !cl && !fl && (!left_occ || adv);
    e_od     = m_head ? mq[0] : m_last;
`ifdef PSR_STALL_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 16'h0000;
`endif
    chk("in_ready",  {32'd0, in_ready},  {32'd0, e_rdy});
    chk("out_valid", {32'd0, out_valid}, {32'd0, m_head});
    chk("out_data",  out_data, e_od);
    chk("stall_cnt", {17'd0, stall_cnt}, {17'd0, e_cnt});
    if (cl) begin
      mq.delete(); m_head = 1'b0; m_last = '0; m_cnt = '0;
    end else if (fl) begin
      mq.delete(); m_head = 1'b0; m_last = '0;
    end else begin
      if (m_head && !ordy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (left_occ) mq[m_head ? 1 : 0] = ref_merge(mq[m_head ? 1 : 0], fd, we);
      if (adv) begin
        if (m_head) void'(mq.pop_front());
        m_last = mq[0];
        m_head = 1'b1;
      end else if (m_head && ordy) begin
        void'(mq.pop_front());
        m_head = 1'b0;
      end
      if (iv && e_rdy) mq.push_back(id);
    end
  endtask

  initial begin
    logic [32:0] d;
    logic [32:0] f;
    clr = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fld_we = '0; fld_data = '0; flush = 1'b0;
    @(posedge clk);

    // Reset: second clr edge, then one accept with out_ready=1
    drive(1'b1, 33'h0_DEAD_BEEF, 1'b1, 5'b0, '0, 1'b0, 1'b1);
    chk("t1_rst_in_ready", {32'd0, in_ready}, 33'd0);
    chk("t1_rst_out_data", out_data, 33'd0);
    drive(1'b1, 33'h1_2345_6789, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t1_out_valid", {32'd0, out_valid}, 33'd1);
    chk("t1_out_data", out_data, 33'h1_2345_6789);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);

    // Back-pressure: A, B accepted, C refused, then all drain in order
    drive(1'b1, 33'h0_0000_00A1, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000_00B2, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000_00C3, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    chk("t2_c_blocked", {32'd0, in_ready}, 33'd0);
    drive(1'b1, 33'h0_0000_00C3, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t2_out_a", out_data, 33'h0_0000_00A1);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t2_out_b", out_data, 33'h0_0000_00B2);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t2_out_c", out_data, 33'h0_0000_00C3);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t2_empty", {32'd0, out_valid}, 33'd0);

    // In-place field overwrite while LEFT is blocked
    drive(1'b1, 33'h0_1111_1111, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_AAAA_AAAA, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 5'b00010, 33'h0_0000_5500, 1'b0, 1'b0);
    chk("t3_full", {32'd0, in_ready}, 33'd0);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t3_first", out_data, 33'h0_1111_1111);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t3_merged", out_data, 33'h0_AAAA_55AA);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);

    // Partial top field written on the advance edge
    drive(1'b1, 33'h0_0000_0001, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 5'b10000, 33'h1_0000_0000, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 5'b0, '0, 1'b0, 1'b0);
    chk("t4_bit32", out_data, 33'h1_0000_0001);

    // Flush with both entries full, then clr mid-stream
    drive(1'b1, 33'h0_0000_0F01, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000_0F02, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000_0F03, 1'b0, 5'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    chk("t5_fl_valid", {32'd0, out_valid}, 33'd0);
    chk("t5_fl_ready", {32'd0, in_ready}, 33'd1);
    chk("t5_fl_data", out_data, 33'd0);
    drive(1'b1, 33'h0_0000_0E01, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000_0E02, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000_0E03, 1'b0, 5'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    chk("t5_clr_valid", {32'd0, out_valid}, 33'd0);
    chk("t5_clr_data", out_data, 33'd0);
    chk("t5_clr_cnt", {17'd0, stall_cnt}, 33'd0);

`ifdef PSR_STALL_CNT_EN
    // Stall counter: 7 stalls, flush holds, clr clears, saturation
    drive(1'b1, 33'h0_0000_0777, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b1, 1'b0);
    chk("t6_cnt7", {17'd0, stall_cnt}, 33'd7);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b1);
    chk("t6_flush_keep", {17'd0, stall_cnt}, 33'd7);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    chk("t6_clr_zero", {17'd0, stall_cnt}, 33'd0);
    drive(1'b1, 33'h0_0000_0888, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b0);
    chk("t6_saturate", {17'd0, stall_cnt}, 33'h0FFFF);
    drive(1'b0, '0, 1'b0, 5'b0, '0, 1'b0, 1'b1);
`endif

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      d[31:0] = $urandom();
      d[32]   = 1'($urandom_range(0, 1));
      f[31:0] = $urandom();
      f[32]   = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), f,
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
